// File: rtl/syscall_printer_pkg.sv
// rtl/syscall_printer_pkg.sv - service codes, state encoding and helper tables for syscall_printer
package syscall_printer_pkg;

    localparam logic [31:0] SYS_PRINT_INT    = 32'd1;
    localparam logic [31:0] SYS_PRINT_STRING = 32'd4;
    localparam logic [31:0] SYS_EXIT         = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR   = 32'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_CHAR,
        SRC_STR,
        SRC_INT
    } src_t;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

    // Big-endian lane select: offset 0 is the most significant byte.
    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] off);
        case (off)
            2'd0:    sel_byte = word[31:24];
            2'd1:    sel_byte = word[23:16];
            2'd2:    sel_byte = word[15:8];
            default: sel_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/syscall_printer_if.sv
// rtl/syscall_printer_if.sv - data-memory read port and console byte stream
interface syscall_printer_if;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;

    modport master (
        output mem_rd, mem_addr, char_data, char_valid,
        input  mem_rdata, char_ready
    );

    modport slave (
        input  mem_rd, mem_addr, char_data, char_valid,
        output mem_rdata, char_ready
    );
endinterface

// File: rtl/syscall_printer_dec_digit_gen.sv
// rtl/syscall_printer_dec_digit_gen.sv - decimal digits of an unsigned magnitude, MSD first
module syscall_printer_dec_digit_gen
    import syscall_printer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mag,
    output logic        digit_valid,
    output logic [3:0]  digit,
    output logic        digit_last,
    input  logic        digit_ready
);

    logic [31:0] rem;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic        busy;
    logic        seen;
    logic [31:0] p;

    assign p          = pow10(idx);
    assign digit      = cnt;
    assign digit_last = (idx == 4'd0);

    // One subtraction per cycle; a zero digit is shown only after a non-zero one or in the units place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            idx         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            seen        <= 1'b0;
            digit_valid <= 1'b0;
        end else if (start) begin
            rem         <= mag;
            idx         <= 4'd9;
            cnt         <= '0;
            busy        <= 1'b1;
            seen        <= 1'b0;
            digit_valid <= 1'b0;
        end else if (digit_valid) begin
            if (digit_ready) begin
                digit_valid <= 1'b0;
                cnt         <= '0;
                if (idx == 4'd0) busy <= 1'b0;
                else             idx  <= idx - 4'd1;
            end
        end else if (busy) begin
            if (rem >= p) begin
                rem <= rem - p;
                cnt <= cnt + 4'd1;
            end else if (cnt != 4'd0 || seen || idx == 4'd0) begin
                digit_valid <= 1'b1;
                seen        <= 1'b1;
            end else begin
                idx <= idx - 4'd1;
            end
        end
    end

endmodule

// File: rtl/syscall_printer.sv
// rtl/syscall_printer.sv - executes print_int/print_string/print_char/exit syscalls onto a byte stream
module syscall_printer
    import syscall_printer_pkg::*;
#(
    parameter int unsigned MAX_STR_LEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              syscall,
    input  logic [31:0]       v0,
    input  logic [31:0]       a0,
    syscall_printer_if.master bus,
    output logic              stall,
    output logic              halt,
    output logic              err
);

    state_t      state, next_state;
    src_t        src;
    logic [31:0] arg;
    logic [31:0] len;
    logic [7:0]  char_q;
    logic        int_last;
    logic        begin_svc;
    logic        len_full;
    logic [7:0]  rd_byte;
    logic [31:0] mag;
    logic        digit_start, digit_valid, digit_ready, digit_last;
    logic [3:0]  digit;

    assign begin_svc = (state == S_IDLE) && syscall && !halt;
    assign len_full  = (len == 32'(MAX_STR_LEN));
    assign rd_byte   = sel_byte(bus.mem_rdata, arg[1:0]);
    assign mag       = a0[31] ? (~a0 + 32'd1) : a0;

    syscall_printer_dec_digit_gen u_digits (
        .clk         (clk),
        .rst         (rst),
        .start       (digit_start),
        .mag         (mag),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_last  (digit_last),
        .digit_ready (digit_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (begin_svc) begin
                    if (v0 == SYS_PRINT_INT)         next_state = a0[31] ? S_EMIT : S_INT;
                    else if (v0 == SYS_PRINT_STRING) next_state = S_FETCH;
                    else if (v0 == SYS_PRINT_CHAR)   next_state = S_EMIT;
                    else                             next_state = S_DONE;
                end
            end
            S_FETCH: next_state = S_WAIT;
            S_WAIT:  next_state = (rd_byte == 8'h00) ? S_DONE : S_EMIT;
            S_INT:   next_state = digit_valid ? S_EMIT : S_INT;
            S_EMIT: begin
                if (bus.char_ready) begin
                    case (src)
                        SRC_STR: next_state = len_full ? S_DONE : S_FETCH;
                        SRC_INT: next_state = int_last ? S_DONE : S_INT;
                        default: next_state = S_DONE;
                    endcase
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rd     = (state == S_FETCH);
        bus.mem_addr   = (state == S_FETCH) ? {arg[31:2], 2'b00} : 32'h0;
        bus.char_valid = (state == S_EMIT);
        bus.char_data  = char_q;
        stall          = begin_svc || (state != S_IDLE && state != S_DONE);
        digit_start    = begin_svc && (v0 == SYS_PRINT_INT);
        digit_ready    = (state == S_INT);
    end

    // A negative int is emitted as '-' first; the digit generator runs in parallel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src      <= SRC_CHAR;
            arg      <= '0;
            len      <= '0;
            char_q   <= '0;
            int_last <= 1'b0;
            halt     <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (begin_svc) begin
                        arg      <= a0;
                        len      <= '0;
                        int_last <= 1'b0;
                        if (v0 == SYS_PRINT_CHAR) begin
                            src    <= SRC_CHAR;
                            char_q <= a0[7:0];
                        end else if (v0 == SYS_PRINT_STRING) begin
                            src <= SRC_STR;
                        end else if (v0 == SYS_PRINT_INT) begin
                            src <= SRC_INT;
                            if (a0[31]) char_q <= 8'h2D;
                        end else if (v0 == SYS_EXIT) begin
                            halt <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (rd_byte != 8'h00) begin
                        char_q <= rd_byte;
                        arg    <= arg + 32'd1;
                        len    <= len + 32'd1;
                    end
                end
                S_INT: begin
                    if (digit_valid) begin
                        char_q   <= 8'h30 + {4'h0, digit};
                        int_last <= digit_last;
                    end
                end
                S_EMIT: begin
                    if (bus.char_ready && src == SRC_STR && len_full) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_printer.sv
// tb/tb_syscall_printer.sv - directed scoreboard bench for syscall_printer
module tb_syscall_printer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        syscall = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        stall, halt, err;

    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          err_cnt = 0;
    int          rdy_mode = 0;
    int unsigned tick = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem[256];
    logic        hold_v = 1'b0;
    logic [7:0]  hold_d = 8'h00;

    syscall_printer_if bus ();

    syscall_printer #(.MAX_STR_LEN(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .syscall (syscall),
        .v0      (v0),
        .a0      (a0),
        .bus     (bus),
        .stall   (stall),
        .halt    (halt),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end

    // Console model: choose ready for the coming edge, then score the handshake it will complete.
    always @(negedge clk) begin
        logic [31:0] want;
        tick++;
        case (rdy_mode)
            0:       bus.char_ready = 1'b1;
            1:       bus.char_ready = (tick % 3 == 0);
            default: bus.char_ready = 1'b0;
        endcase
        if (bus.mem_rd) rd_cnt++;
        if (err) err_cnt++;
        if (hold_v && rdy_mode == 1) begin
            check("hold_valid", {31'h0, bus.char_valid}, 32'h1);
            check("hold_data", {24'h0, bus.char_data}, {24'h0, hold_d});
        end
        if (bus.char_valid && bus.char_ready) begin
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h100;
            check("char", {24'h0, bus.char_data}, want);
        end
        hold_v = bus.char_valid && !bus.char_ready;
        hold_d = bus.char_data;
    end

    task automatic put_byte(input logic [31:0] addr, input logic [7:0] b);
        mem[addr[9:2]][8*(3-addr[1:0]) +: 8] = b;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({24'h0, s[i]});
    endtask

    task automatic run_sys(input logic [31:0] v, input logic [31:0] a, output int n);
        @(negedge clk);
        syscall = 1'b1;
        v0 = v;
        a0 = a;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (!stall) break;
            n++;
            @(negedge clk);
        end
        check("stall_released", {31'h0, stall}, 32'h0);
        syscall = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h0);
    endtask

    initial begin
        int n, rd0, e0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        put_byte(32'h1001_0002, 8'h48);
        put_byte(32'h1001_0003, 8'h69);
        put_byte(32'h0000_0020, 8'h61);
        put_byte(32'h0000_0021, 8'h62);
        put_byte(32'h0000_0022, 8'h63);
        mem[16] = 32'h7778_797A;
        mem[17] = 32'h7778_797A;

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_char_valid", {31'h0, bus.char_valid}, 32'h0);
        check("rst_char_data", {24'h0, bus.char_data}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_halt", {31'h0, halt}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        e0 = err_cnt;
        push_str("A");
        run_sys(32'd11, 32'h41, n);
        check("char_stall_cycles", n, 32'd2);
        check("char_no_err", err_cnt - e0, 32'h0);

        rd0 = rd_cnt; e0 = err_cnt;
        push_str("Hi");
        run_sys(32'd4, 32'h1001_0002, n);
        check("hi_mem_reads", rd_cnt - rd0, 32'd3);
        check("hi_no_err", err_cnt - e0, 32'h0);

        push_str("-7");
        run_sys(32'd1, 32'hFFFF_FFF9, n);
        push_str("0");
        run_sys(32'd1, 32'h0, n);
        push_str("-2147483648");
        run_sys(32'd1, 32'h8000_0000, n);
        push_str("1000");
        run_sys(32'd1, 32'd1000, n);

        rdy_mode = 1;
        e0 = err_cnt;
        push_str("abc");
        run_sys(32'd4, 32'h20, n);
        check("slow_no_err", err_cnt - e0, 32'h0);
        rdy_mode = 0;

        rd0 = rd_cnt; e0 = err_cnt;
        push_str("wxyz");
        run_sys(32'd4, 32'h40, n);
        check("overrun_err", err_cnt - e0, 32'd1);
        check("overrun_reads", rd_cnt - rd0, 32'd4);

        e0 = err_cnt;
        run_sys(32'd7, 32'h41, n);
        check("bad_code_err", err_cnt - e0, 32'd1);
        check("bad_code_stall", n, 32'd1);

        run_sys(32'd10, 32'h0, n);
        check("exit_halt", {31'h0, halt}, 32'h1);
        run_sys(32'd11, 32'h42, n);
        check("halted_ignores", n, 32'h0);
        check("halt_sticky", {31'h0, halt}, 32'h1);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_clears_halt", {31'h0, halt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        rdy_mode = 2;
        @(negedge clk);
        syscall = 1'b1;
        v0 = 32'd11;
        a0 = 32'h5A;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.char_valid) break;
            @(negedge clk);
        end
        check("emit_reached", {31'h0, bus.char_valid}, 32'h1);
        syscall = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'h0, bus.char_valid}, 32'h0);
        check("midrst_stall", {31'h0, stall}, 32'h0);
        check("midrst_data", {24'h0, bus.char_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_idle", {31'h0, bus.char_valid}, 32'h0);
        check("post_rst_queue", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
